// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared types and defaults for the stream cipher key path
package stream_cipher_pkg;
  localparam int KEY_WIDTH_BYTES_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, SEND, DONE} key_rb_state_t;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/key_readback_serializer.sv
// key_readback_serializer: snapshots the stored key and streams it out byte 0 first over valid/ready
module key_readback_serializer
  import stream_cipher_pkg::*;
#(
  parameter int KEY_WIDTH_BYTES = KEY_WIDTH_BYTES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KEY_WIDTH_BYTES*8-1:0] key_memory_in,
  input  logic                         start_pulse,
  input  logic                         abort,
  input  logic                         out_ready,
  output byte_t                        out_byte,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done_pulse
);
  localparam int IW = $clog2(KEY_WIDTH_BYTES);
  localparam logic [IW-1:0] LAST = IW'(KEY_WIDTH_BYTES - 1);
  key_rb_state_t r_state, w_next;
  logic [KEY_WIDTH_BYTES*8-1:0] r_snapshot;
  logic [IW-1:0] r_index;
  logic w_hs;
  logic w_last;
  assign w_hs   = (r_state == SEND) && out_ready && !abort;
  assign w_last = r_index == LAST;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (start_pulse ? SEND : IDLE) :
             (r_state == SEND) ? (abort ? IDLE : (w_hs && w_last) ? DONE : SEND) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_snapshot <= '0;
      r_index    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_pulse) begin
        r_snapshot <= key_memory_in;
        r_index    <= '0;
      end else if (w_hs) begin
        r_index <= w_last ? '0 : r_index + 1'b1;
      end
    end
  end
  // Outputs decode registered state only, so nothing passes combinationally from inputs
  assign out_valid  = r_state == SEND;
  assign busy       = r_state == SEND;
  assign done_pulse = r_state == DONE;
  assign out_byte   = out_valid ? r_snapshot[{r_index, 3'b000} +: 8] : '0;
endmodule

// File: tb/tb_key_readback_serializer.sv
// tb_key_readback_serializer: scoreboard bench with directed scenarios and random keys/backpressure
module tb_key_readback_serializer;
  logic clk = 0;
  logic rst = 1;
  logic [127:0] key_memory_in = '0;
  logic start_pulse = 0, abort = 0, out_ready = 0;
  logic [7:0] out_byte;
  logic out_valid, busy, done_pulse;
  int checks = 0, failures = 0;
  int n_sent = 0, n_done = 0;
  bit exp_done = 0;
  logic [7:0] q[$];
  localparam logic [127:0] BASIC = 128'h0F0E0D0C0B0A09080706050403020100;

  always #5 clk = ~clk;

  key_readback_serializer #(.KEY_WIDTH_BYTES(16)) dut (
    .clk(clk), .rst(rst), .key_memory_in(key_memory_in), .start_pulse(start_pulse),
    .abort(abort), .out_ready(out_ready), .out_byte(out_byte), .out_valid(out_valid),
    .busy(busy), .done_pulse(done_pulse)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and polices hold and done behaviour
  initial begin
    logic pv, pr, pa;
    logic [7:0] pb;
    pv = 0; pr = 0; pa = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv && !pr && !pa) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_byte", out_byte, pb);
        end
        if (out_valid && out_ready && !abort) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_byte: got %0h expected no byte", out_byte);
          end else chk("byte", out_byte, q.pop_front());
          n_sent++;
        end
        if (done_pulse) begin
          chk("done_expected", exp_done, 1);
          chk("done_after_all_bytes", q.size(), 0);
          exp_done = 0;
          n_done++;
        end
      end
      pv = out_valid && !rst;
      pr = out_ready;
      pa = abort;
      pb = out_byte;
    end
  end

  task automatic xfer(input logic [127:0] key, input int abort_at, input int restart_at,
                      input int rst_at, input int chg_at, input int stall_at, input bit rnd,
                      input int exp_cyc);
    int base, k, cyc, st, dn0;
    bit fin, ab, rs;
    base = n_sent; dn0 = n_done; cyc = 0; st = 0; fin = 0; ab = 0; rs = 0;
    key_memory_in = key;
    start_pulse = 1;
    for (int i = 0; i < 16; i++) q.push_back(key[i*8 +: 8]);
    exp_done = 1;
    @(posedge clk); #1;
    start_pulse = 0;
    chk("first_valid", out_valid, 1);
    chk("first_byte", out_byte, key[7:0]);
    chk("first_busy", busy, 1);
    while (!fin && cyc < 200) begin
      k = n_sent - base;
      if (k == stall_at && st < 3) begin
        out_ready = 0;
        st++;
      end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort = (k == abort_at);
      start_pulse = (k == restart_at);
      rst = (k == rst_at);
      ab = abort;
      rs = rst;
      if (k == chg_at) key_memory_in = ~key;
      @(posedge clk); #1;
      cyc++;
      abort = 0; start_pulse = 0; rst = 0;
      if (ab) begin
        chk("abort_valid_low", out_valid, 0);
        chk("abort_busy_low", busy, 0);
        q.delete();
        exp_done = 0;
        fin = 1;
      end else if (rs) begin
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_byte", out_byte, 0);
        q.delete();
        exp_done = 0;
        fin = 1;
      end else if (done_pulse) begin
        fin = 1;
        chk("done_busy_low", busy, 0);
        chk("bytes_sent", n_sent - base, 16);
        if (exp_cyc > 0) chk("done_cycle", cyc + 1, exp_cyc);
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no completion expected done within 200 cycles");
      q.delete();
      exp_done = 0;
    end
    out_ready = 0;
    @(posedge clk); #1;
    chk("done_one_cycle", done_pulse, 0);
    chk("idle_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", n_done - dn0, (ab || rs) ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done_pulse, 0);
    chk("reset_byte", out_byte, 0);
    rst = 0;
    @(posedge clk); #1;
    xfer(BASIC, -1, -1, -1, -1, -1, 0, 17);
    xfer(BASIC, -1, -1, -1, -1, 5, 0, 20);
    xfer({16{8'hAA}}, -1, -1, -1, 3, -1, 0, 17);
    xfer(BASIC, 7, -1, -1, -1, -1, 0, 0);
    xfer(BASIC, -1, -1, -1, -1, -1, 0, 17);
    xfer(BASIC, -1, 4, -1, -1, -1, 0, 17);
    xfer(BASIC, -1, -1, 9, -1, -1, 0, 0);
    xfer(BASIC, -1, -1, -1, -1, -1, 0, 17);
    for (int t = 0; t < 20; t++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      xfer(rk, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
           -1, -1, -1, -1, 1, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
